// File: rtl/gopher_pkg.sv
// gopher_pkg: shared types and helpers for the Hit-Gophers channel controller.
//   ch_state_t : per-channel gopher state (idle / gopher up / post-hit display)
//   sat_add    : unsigned add clamped to a caller-supplied maximum
package gopher_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_UP   = 2'd1,
    CH_HIT  = 2'd2
  } ch_state_t;

  // Unsigned add clamped to max. The 33-bit sum keeps the carry so a wrapped
  // result can never slip under the clamp.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/gopher_debounce.sv
// gopher_debounce: one key channel front end.
//   Two-flop synchroniser, then a debouncer whose stable level follows the
//   synced level only after DEB_CYCLES consecutive cycles of disagreement;
//   any agreement clears the run. press pulses for one cycle on the edge at
//   which the stable level goes 0 -> 1. Releases produce no pulse.
// Ports:
//   gclk   in  system clock
//   greset in  synchronous reset, active-high
//   key    in  raw asynchronous key, 1 = pressed
//   press  out one-cycle registered pulse on debounced press
module gopher_debounce #(
  parameter int DEB_CYCLES = 270000
) (
  input  logic gclk,
  input  logic greset,
  input  logic key,
  output logic press
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [DW-1:0] run_cnt;

  // NOTE: non-blocking assignments keep sync1 -> sync2 a true two-stage shift;
  // blocking ones here would collapse the synchroniser into a single flop.
  always_ff @(posedge gclk) begin
    if (greset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      stable  <= 1'b0;
      run_cnt <= '0;
      press   <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        run_cnt <= '0;
      end else if (run_cnt == DEB_LAST) begin
        // Last disagreeing cycle of the run: adopt the new level.
        stable  <= sync2;
        run_cnt <= '0;
        press   <= sync2;
      end else begin
        run_cnt <= run_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/gopher_channel_ctrl.sv
// gopher_channel_ctrl: NUM_CH independent key+LED mole channels.
//   Each channel debounces its key, raises a gopher (LED lit) when the game
//   logic spawns one on it, and reports hit / miss / wrong-press pulses. Two
//   shared saturating counters total hits and misses (misses + wrong presses).
// Optional feature: define GOPHER_BLINK_EN to blink the LED during the
//   post-hit display (toggle every BLINK_CYCLES, lit on entry); otherwise the
//   LED is dark in that state and no blink counter exists.
// Ports:
//   gclk, greset               clock, synchronous active-high reset
//   key[NUM_CH]                raw keys, 1 = pressed
//   spawn_valid, spawn_ch      gopher request and target channel
//   spawn_ready                target channel exists and is idle (combinational)
//   led[NUM_CH]                1 = lit
//   hit/miss/wrong_pulse       one-cycle event pulses per channel
//   hit_cnt, miss_cnt          saturating totals
module gopher_channel_ctrl
  import gopher_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DEB_CYCLES   = 270000,
  parameter int UP_CYCLES    = 27000000,
  parameter int HIT_CYCLES   = 6750000,
  parameter int BLINK_CYCLES = 1350000,
  parameter int CNT_W        = 8,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              gclk,
  input  logic              greset,
  input  logic [NUM_CH-1:0] key,
  input  logic              spawn_valid,
  input  logic [CH_W-1:0]   spawn_ch,
  output logic              spawn_ready,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] hit_pulse,
  output logic [NUM_CH-1:0] miss_pulse,
  output logic [NUM_CH-1:0] wrong_pulse,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  if (NUM_CH < 1 || NUM_CH > 16 || DEB_CYCLES < 1 || UP_CYCLES < 1 ||
      HIT_CYCLES < 1 || BLINK_CYCLES < 1 || CNT_W < 1 || CNT_W > 31) begin : g_bad_params
    $error("gopher_channel_ctrl: parameter out of range");
  end

  // One timer per channel serves both the UP and HIT windows.
  localparam int TMR_MAX = (UP_CYCLES > HIT_CYCLES) ? UP_CYCLES : HIT_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] UP_LAST  = TMR_W'(UP_CYCLES - 1);
  localparam logic [TMR_W-1:0] HIT_LAST = TMR_W'(HIT_CYCLES - 1);
  localparam logic [31:0]      CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);

`ifdef GOPHER_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic HIT_LED = 1'b1;
`else
  localparam logic HIT_LED = 1'b0;
`endif

  logic [NUM_CH-1:0]    press;
  logic [NUM_CH-1:0]    idle;
  logic [NUM_CH-1:0]    hit_ev;
  logic [NUM_CH-1:0]    miss_ev;
  logic [NUM_CH-1:0]    wrong_ev;
  logic [2**CH_W-1:0]   idle_ext;

  // Pad the idle vector to the full spawn_ch range so out-of-range channel
  // numbers read as not ready.
  // NOTE: the default assignment comes first so every path assigns idle_ext
  // and no latch is inferred.
  always_comb begin
    idle_ext             = '0;
    idle_ext[NUM_CH-1:0] = idle;
  end

  assign spawn_ready = idle_ext[spawn_ch];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    ch_state_t        state;
    logic [TMR_W-1:0] timer;
    logic             accept;
    logic             led_r;
    logic             hit_r;
    logic             miss_r;
    logic             wrong_r;
`ifdef GOPHER_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt;
`endif

    gopher_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .gclk   (gclk),
      .greset (greset),
      .key    (key[ch]),
      .press  (press[ch])
    );

    assign idle[ch]     = (state == CH_IDLE);
    assign accept       = spawn_valid && spawn_ready && (spawn_ch == CH_W'(ch));
    // A press on the timeout cycle is a hit, not a miss.
    assign hit_ev[ch]   = (state == CH_UP) && press[ch];
    assign miss_ev[ch]  = (state == CH_UP) && !press[ch] && (timer == UP_LAST);
    assign wrong_ev[ch] = (state != CH_UP) && press[ch];

    always_ff @(posedge gclk) begin
      if (greset) begin
        state   <= CH_IDLE;
        timer   <= '0;
        led_r   <= 1'b0;
        hit_r   <= 1'b0;
        miss_r  <= 1'b0;
        wrong_r <= 1'b0;
`ifdef GOPHER_BLINK_EN
        blink_cnt <= '0;
`endif
      end else begin
        hit_r   <= hit_ev[ch];
        miss_r  <= miss_ev[ch];
        wrong_r <= wrong_ev[ch];
        unique case (state)
          CH_IDLE: begin
            timer <= '0;
            if (accept) begin
              state <= CH_UP;
              led_r <= 1'b1;
            end
          end
          CH_UP: begin
            if (hit_ev[ch]) begin
              state <= CH_HIT;
              timer <= '0;
              led_r <= HIT_LED;
`ifdef GOPHER_BLINK_EN
              blink_cnt <= '0;
`endif
            end else if (miss_ev[ch]) begin
              state <= CH_IDLE;
              timer <= '0;
              led_r <= 1'b0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          CH_HIT: begin
            if (timer == HIT_LAST) begin
              state <= CH_IDLE;
              timer <= '0;
              led_r <= 1'b0;
            end else begin
              timer <= timer + TMR_W'(1);
`ifdef GOPHER_BLINK_EN
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                led_r     <= ~led_r;
              end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
              end
`endif
            end
          end
          default: begin
            state <= CH_IDLE;
            timer <= '0;
            led_r <= 1'b0;
          end
        endcase
      end
    end

    assign led[ch]         = led_r;
    assign hit_pulse[ch]   = hit_r;
    assign miss_pulse[ch]  = miss_r;
    assign wrong_pulse[ch] = wrong_r;
  end

  // Counters step on the same edge that raises the pulses, adding every
  // channel's event of that cycle at once.
  always_ff @(posedge gclk) begin
    if (greset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      hit_cnt  <= CNT_W'(sat_add(32'(hit_cnt), 32'($countones(hit_ev)), CNT_MAX));
      miss_cnt <= CNT_W'(sat_add(32'(miss_cnt),
                                 32'($countones(miss_ev)) + 32'($countones(wrong_ev)),
                                 CNT_MAX));
    end
  end

endmodule

// File: tb/tb_gopher_channel_ctrl.sv
// tb_gopher_channel_ctrl: directed + randomized bench for gopher_channel_ctrl.
// A behavioural model keeps the raw key history and absolute entry cycles of
// each gopher, and derives every expected output from those each cycle.
module tb_gopher_channel_ctrl;

  localparam int NUM_CH       = 4;
  localparam int DEB_CYCLES   = 4;
  localparam int UP_CYCLES    = 20;
  localparam int HIT_CYCLES   = 8;
  localparam int BLINK_CYCLES = 2;
  localparam int CNT_W        = 3;
  localparam int CNT_MAX      = 7;
  localparam int S_IDLE = 0, S_UP = 1, S_HIT = 2;

  logic              gclk = 1'b0;
  logic              greset;
  logic [NUM_CH-1:0] key;
  logic              spawn_valid;
  logic [1:0]        spawn_ch;
  logic              spawn_ready;
  logic [NUM_CH-1:0] led, hit_pulse, miss_pulse, wrong_pulse;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;

  gopher_channel_ctrl #(
    .NUM_CH(NUM_CH), .DEB_CYCLES(DEB_CYCLES), .UP_CYCLES(UP_CYCLES),
    .HIT_CYCLES(HIT_CYCLES), .BLINK_CYCLES(BLINK_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .gclk(gclk), .greset(greset), .key(key), .spawn_valid(spawn_valid),
    .spawn_ch(spawn_ch), .spawn_ready(spawn_ready), .led(led),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .wrong_pulse(wrong_pulse),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 gclk = ~gclk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // ---------------- reference model ----------------
  int                m_n;                 // edges seen so far
  int                m_st    [NUM_CH];
  int                m_enter [NUM_CH];    // edge at which current state began
  bit                m_stable[NUM_CH];
  bit                m_press [NUM_CH];    // debounced press seen by next edge
  logic [NUM_CH-1:0] khist[$];            // key value sampled at each edge
  logic [NUM_CH-1:0] e_led, e_hit, e_miss, e_wrong;
  int                e_hit_cnt, e_miss_cnt;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_st[c] = S_IDLE; m_enter[c] = 0; m_stable[c] = 0; m_press[c] = 0;
    end
    khist.delete();
    // Synchroniser flops hold 0 after reset: treat as zero samples.
    for (int j = 0; j < DEB_CYCLES + 2; j++) khist.push_back('0);
    e_led = '0; e_hit = '0; e_miss = '0; e_wrong = '0;
    e_hit_cnt = 0; e_miss_cnt = 0;
  endtask

  task automatic model_edge();
    bit ready;
    bit all_diff;
    int nh, nm;
    m_n++;
    if (greset) begin
      model_reset();
    end else begin
      ready = (int'(spawn_ch) < NUM_CH) && (m_st[spawn_ch] == S_IDLE);
      e_hit = '0; e_miss = '0; e_wrong = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        case (m_st[c])
          S_IDLE: begin
            if (m_press[c]) e_wrong[c] = 1'b1;
            if (spawn_valid && ready && int'(spawn_ch) == c) begin
              m_st[c] = S_UP; m_enter[c] = m_n;
            end
          end
          S_UP: begin
            if (m_press[c]) begin
              e_hit[c] = 1'b1; m_st[c] = S_HIT; m_enter[c] = m_n;
            end else if (m_n - m_enter[c] == UP_CYCLES) begin
              e_miss[c] = 1'b1; m_st[c] = S_IDLE;
            end
          end
          default: begin
            if (m_press[c]) e_wrong[c] = 1'b1;
            if (m_n - m_enter[c] == HIT_CYCLES) m_st[c] = S_IDLE;
          end
        endcase
      end
      nh = 0; nm = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        nh += int'(e_hit[c]);
        nm += int'(e_miss[c]) + int'(e_wrong[c]);
      end
      e_hit_cnt  = (e_hit_cnt + nh > CNT_MAX) ? CNT_MAX : e_hit_cnt + nh;
      e_miss_cnt = (e_miss_cnt + nm > CNT_MAX) ? CNT_MAX : e_miss_cnt + nm;
      // Debounce: the level flips when the DEB_CYCLES samples that reached
      // the debouncer (two edges late) all disagree with the current level.
      khist.push_back(key);
      for (int c = 0; c < NUM_CH; c++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DEB_CYCLES; j++)
          if (khist[khist.size() - 3 - j][c] == m_stable[c]) all_diff = 1'b0;
        m_press[c] = 1'b0;
        if (all_diff) begin
          m_stable[c] = !m_stable[c];
          m_press[c]  = m_stable[c];
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      e_led[c] = (m_st[c] == S_UP);
`ifdef GOPHER_BLINK_EN
      if (m_st[c] == S_HIT)
        e_led[c] = (((m_n - m_enter[c]) / BLINK_CYCLES) % 2) == 0;
`endif
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, m_n);
    end
  endtask

  task automatic compare_all();
    bit e_ready;
    e_ready = (int'(spawn_ch) < NUM_CH) && (m_st[spawn_ch] == S_IDLE);
    check("led",         32'(led),         32'(e_led));
    check("hit_pulse",   32'(hit_pulse),   32'(e_hit));
    check("miss_pulse",  32'(miss_pulse),  32'(e_miss));
    check("wrong_pulse", 32'(wrong_pulse), 32'(e_wrong));
    check("hit_cnt",     32'(hit_cnt),     32'(e_hit_cnt));
    check("miss_cnt",    32'(miss_cnt),    32'(e_miss_cnt));
    check("spawn_ready", 32'(spawn_ready), 32'(e_ready));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge gclk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic spawn(input int ch);
    spawn_valid = 1'b1;
    spawn_ch    = 2'(ch);
    step();
    spawn_valid = 1'b0;
  endtask

  logic exp_hit_led;
  int   ch_r, dly;

  initial begin
    greset = 1'b1; key = '0; spawn_valid = 1'b0; spawn_ch = '0;
    m_n = 0;
    model_reset();
    repeat (3) step();
    greset = 1'b0;

    // Idle after reset.
    repeat (50) step();
    check("idle_led",      32'(led),         32'h0);
    check("idle_pulses",   32'({hit_pulse, miss_pulse, wrong_pulse}), 32'h0);
    check("idle_hit_cnt",  32'(hit_cnt),     32'h0);
    check("idle_miss_cnt", 32'(miss_cnt),    32'h0);
    check("idle_ready",    32'(spawn_ready), 32'h1);

    // Spawn ch2; a 3-cycle press is filtered, a held press hits.
    spawn(2);
    check("spawn2_led", 32'(led), 32'b0100);
    key[2] = 1'b1;
    repeat (3) step();
    key[2] = 1'b0;
    repeat (8) step();
    check("short_press_hits", 32'(hit_cnt), 32'h0);
    key[2] = 1'b1;
`ifdef GOPHER_BLINK_EN
    exp_hit_led = 1'b1;
`else
    exp_hit_led = 1'b0;
`endif
    for (int i = 1; i <= 10; i++) begin
      step();
      // i == 1 is the first edge sampling the key; the hit lands 6 edges later.
      if (i == 6) check("hit_early", 32'(hit_pulse), 32'h0);
      if (i == 7) begin
        check("hit_latency", 32'(hit_pulse), 32'b0100);
        check("hit_led2",    32'(led[2]),    32'(exp_hit_led));
        check("hit_cnt_1",   32'(hit_cnt),   32'h1);
      end
    end
    key[2] = 1'b0;
    repeat (12) step();
    spawn_ch = 2'd2;
    #1 check("hit_done_ready", 32'(spawn_ready), 32'h1);

    // Spawn ch0 with no press; repeat request while UP is refused.
    spawn(0);
    spawn_valid = 1'b1; spawn_ch = 2'd0;
    #1 check("busy_ready", 32'(spawn_ready), 32'h0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 3) spawn_valid = 1'b0;
      if (i == 19) check("miss_early", 32'(miss_pulse), 32'h0);
      if (i == 20) begin
        check("miss_at_20", 32'(miss_pulse), 32'b0001);
        check("miss_cnt_1", 32'(miss_cnt),   32'h1);
      end
    end
    repeat (3) step();

    // Simultaneous wrong presses on idle ch1 and ch3.
    key = 4'b1010;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 7) begin
        check("wrong_both",   32'(wrong_pulse), 32'b1010);
        check("wrong_cnt_+2", 32'(miss_cnt),    32'h3);
      end
    end
    key = '0;
    repeat (10) step();

    // Debounced press lands on the timeout edge: hit wins.
    spawn(1);
    repeat (13) step();
    key[1] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 7) begin
        check("race_hit",  32'(hit_pulse),  32'b0010);
        check("race_miss", 32'(miss_pulse), 32'h0);
      end
    end
    key[1] = 1'b0;
    repeat (12) step();

    // Nine more hits saturate hit_cnt at 7.
    for (int h = 0; h < 9; h++) begin
      ch_r = int'($urandom_range(0, NUM_CH - 1));
      dly  = int'($urandom_range(0, 10));
      spawn(ch_r);
      repeat (dly) step();
      key[ch_r] = 1'b1;
      repeat (8) step();
      key[ch_r] = 1'b0;
      repeat (12) step();
    end
    check("hit_sat", 32'(hit_cnt), 32'h7);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 7) == 0) key[c] = ~key[c];
      spawn_valid = ($urandom_range(0, 3) == 0);
      spawn_ch    = 2'($urandom_range(0, NUM_CH - 1));
      step();
    end
    key = '0; spawn_valid = 1'b0;
    repeat (30) step();

    // Reset while a gopher is up: no miss afterwards.
    spawn(3);
    repeat (5) step();
    greset = 1'b1;
    step();
    check("abort_led", 32'(led), 32'h0);
    greset = 1'b0;
    repeat (30) step();
    check("abort_miss_cnt", 32'(miss_cnt), 32'h0);
    check("abort_hit_cnt",  32'(hit_cnt),  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/gopher_channel_ctrl.md
# gopher_channel_ctrl

Parametrised N-channel mole controller for the Hit-Gophers board: generalises the single key/LED top-level path to NUM_CH independent key+LED channels. Each channel debounces its raw key, lights its LED when the game logic spawns a gopher on it, and reports hit or miss with per-event pulses and saturating score counters. Sits between the raw board pins and the game/scoring logic.

## Interface
- NUM_CH, 4: number of key/LED channels (1..16)
- DEB_CYCLES, 270000: consecutive stable cycles to accept a key level (10 ms at 27 MHz)
- UP_CYCLES, 27000000: gopher visible time in cycles (1 s)
- HIT_CYCLES, 6750000: post-hit display time in cycles (250 ms)
- BLINK_CYCLES, 1350000: blink half-period in cycles (50 ms), used only with blink feature
- CNT_W, 8: width of hit/miss counters
- gclk  in  1  system clock, 27 MHz
- greset  in  1  synchronous reset, active-high
- key  in  NUM_CH  raw asynchronous keys, 1 = pressed
- spawn_valid  in  1  request to raise a gopher
- spawn_ch  in  clog2(NUM_CH)  target channel of request
- spawn_ready  out  1  selected channel is IDLE (combinational from spawn_ch and state)
- led  out  NUM_CH  1 = LED lit
- hit_pulse  out  NUM_CH  one-cycle pulse on hit
- miss_pulse  out  NUM_CH  one-cycle pulse on timeout
- wrong_pulse  out  NUM_CH  one-cycle pulse on press of channel with no gopher
- hit_cnt  out  CNT_W  total hits, saturating
- miss_cnt  out  CNT_W  total misses + wrong presses, saturating

## Operation
- Per channel: 2-FF synchroniser, then debouncer; stable level changes after DEB_CYCLES consecutive cycles of differing synced level; counter clears when synced level equals stable level.
- press = one-cycle pulse on debounced 0->1 edge; releases generate nothing.
- Channel FSM states: IDLE, UP, HIT.
- IDLE -> UP when spawn_valid && spawn_ready && spawn_ch==ch; timer cleared.
- UP -> HIT on press: hit_pulse, hit_cnt+1, timer cleared.
- UP -> IDLE when timer == UP_CYCLES-1 without press: miss_pulse, miss_cnt+1.
- HIT -> IDLE when timer == HIT_CYCLES-1.
- IDLE or HIT with press: wrong_pulse, miss_cnt+1, no state change.
- led = 1 in UP; 0 in IDLE; HIT per Configuration.
- Counters saturate at 2^CNT_W-1; several channels in one cycle add their pulse count (popcount), clamped.
- spawn_ch >= NUM_CH: spawn_ready = 0, request ignored.

## Timing
- Reset: all FSMs IDLE, timers 0, debounced levels 0, led 0, all pulses 0, hit_cnt 0, miss_cnt 0. Mid-operation reset aborts any UP/HIT with no pulse.
- Raw key held: press pulse asserted 2+DEB_CYCLES cycles after the first clock edge sampling the new level.
- Press -> hit_pulse and state HIT: next edge (1 cycle); led drops/blinks from that edge.
- Spawn accepted on edge t: led high from t+1; miss_pulse at t+UP_CYCLES if no press.
- Press and timeout on same cycle: hit wins.
- Spawn handshake: accepted only on cycle where valid && ready; no buffering.
- Counters update 1 cycle after the event edge, i.e. same edge as the pulse.

## Configuration
- GOPHER_BLINK_EN defined: in HIT, led toggles every BLINK_CYCLES, starting lit on entry.
- Undefined: led = 0 in HIT; BLINK_CYCLES unused, no blink counter synthesised.

## Structure
- gopher_pkg: channel state typedef (IDLE/UP/HIT), saturating-add helper function.
- Sub-module gopher_debounce (sync + debounce + rising-edge pulse), instantiated NUM_CH times via generate.

## Test plan
- Overrides DEB_CYCLES=4, UP_CYCLES=20, HIT_CYCLES=8, BLINK_CYCLES=2, NUM_CH=4, CNT_W=3.
- Reset, no stimulus 50 cycles -> led=0000, all pulses 0, counters 0, spawn_ready=1.
- Spawn ch2, press key[2] 3 cycles -> no press; hold 10 cycles -> hit_pulse[2] 6 cycles after key rise, hit_cnt=1, led[2] low (or blinks with period 4 if GOPHER_BLINK_EN), IDLE after 8 cycles.
- Spawn ch0, no press -> miss_pulse[0] exactly 20 cycles after acceptance, miss_cnt=1; spawn ch0 while UP -> spawn_ready=0, not accepted.
- Press key[1] on IDLE channel and key[3] simultaneously -> wrong_pulse=1010, miss_cnt +2 same cycle.
- Press timed so debounced edge lands on timeout cycle -> hit_pulse only; 9 hits -> hit_cnt stays 7; reset while UP -> led 0, no miss_pulse.
